gelato_register_bank_arbiter: RTL and testbench



---
 rtl/gelato_register_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_gelato_register_bank_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_register_bank_arbiter.sv
// Banked vector register file with a per-bank read arbiter between the operand
// collector's request and response ports; the writeback port wins bank conflicts.
module gelato_register_bank_arbiter #(
   parameter int COLLECTOR_SIZE = 4,
   parameter int BANK_NUM       = 4,
   parameter int REG_AW         = 5,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               rdy,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [COLLECTOR_SIZE-1:0]          req_entry_valid,
   input  logic [COLLECTOR_SIZE*2-1:0]        req_collector_num,
   input  logic [COLLECTOR_SIZE*3*REG_AW-1:0] req_reg_num,
   input  logic [COLLECTOR_SIZE*3-1:0]        req_reg_valid,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [BANK_NUM-1:0]                resp_data_valid,
   output logic [BANK_NUM*2-1:0]              resp_collector_index,
   output logic [BANK_NUM*2-1:0]              resp_reg_index,
   output logic [BANK_NUM*DATA_WIDTH-1:0]     resp_data,
   input  logic                               wb_valid,
   input  logic [REG_AW-1:0]                  wb_reg,
   input  logic [DATA_WIDTH-1:0]              wb_data
);

   localparam int BANK_W = $clog2(BANK_NUM);
   localparam int ROW_W  = REG_AW - BANK_W;
   localparam int ROWS   = 1 << ROW_W;
   localparam int TAG_W  = 2;
   localparam int IDX_W  = 2;

   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] mem [BANK_NUM][ROWS];

   logic [BANK_NUM-1:0] cand_hit;
   logic [ROW_W-1:0]    cand_row [BANK_NUM];
   logic [TAG_W-1:0]    cand_tag [BANK_NUM];
   logic [IDX_W-1:0]    cand_idx [BANK_NUM];

   logic [BANK_NUM-1:0] done;
   logic [BANK_NUM-1:0] issue;
   logic [ROW_W-1:0]    lat_row [BANK_NUM];
   logic [TAG_W-1:0]    lat_tag [BANK_NUM];
   logic [IDX_W-1:0]    lat_idx [BANK_NUM];

   logic [BANK_W-1:0] wb_bank;
   logic [ROW_W-1:0]  wb_row;

   assign wb_bank    = wb_reg[BANK_W-1:0];
   assign wb_row     = wb_reg[REG_AW-1:BANK_W];
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   // First valid operand per bank in scan order: entry 0..N-1, operand 1..3.
   always_comb begin
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
         cand_hit[b] = 1'b0;
         cand_row[b] = '0;
         cand_tag[b] = '0;
         cand_idx[b] = '0;
         for (int unsigned e = 0; e < COLLECTOR_SIZE; e++) begin
            for (int unsigned o = 0; o < 3; o++) begin
               if (!cand_hit[b] && req_entry_valid[e] && req_reg_valid[e*3+o] &&
                   req_reg_num[(e*3+o)*REG_AW +: BANK_W] == BANK_W'(b)) begin
                  cand_hit[b] = 1'b1;
                  cand_row[b] = req_reg_num[(e*3+o)*REG_AW+BANK_W +: ROW_W];
                  cand_tag[b] = req_collector_num[e*TAG_W +: TAG_W];
                  cand_idx[b] = IDX_W'(o + 1);
               end
            end
         end
      end
   end

   always_comb begin
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
         issue[b] = (state == READ) && !done[b] &&
                    !(wb_valid && wb_bank == BANK_W'(b));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rdy && req_valid)  state_nxt = READ;
         READ:    if (rdy && (&done))    state_nxt = RESP;
         RESP:    if (rdy && resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done                 <= '0;
         resp_data_valid      <= '0;
         resp_collector_index <= '0;
         resp_reg_index       <= '0;
         resp_data            <= '0;
         for (int unsigned b = 0; b < BANK_NUM; b++) begin
            lat_row[b] <= '0;
            lat_tag[b] <= '0;
            lat_idx[b] <= '0;
            for (int unsigned r = 0; r < ROWS; r++) mem[b][r] <= '0;
         end
      end else if (rdy) begin
         if (wb_valid) mem[wb_bank][wb_row] <= wb_data;
         if (state == IDLE && req_valid) begin
            for (int unsigned b = 0; b < BANK_NUM; b++) begin
               done[b]            <= !cand_hit[b];
               resp_data_valid[b] <= 1'b0;
               lat_row[b]         <= cand_row[b];
               lat_tag[b]         <= cand_tag[b];
               lat_idx[b]         <= cand_idx[b];
            end
         end else if (state == READ) begin
            // Read sees pre-edge contents; a same-bank write blocks the read, so retry gets new data.
            for (int unsigned b = 0; b < BANK_NUM; b++) begin
               if (issue[b]) begin
                  resp_data[b*DATA_WIDTH +: DATA_WIDTH]  <= mem[b][lat_row[b]];
                  resp_collector_index[b*TAG_W +: TAG_W] <= lat_tag[b];
                  resp_reg_index[b*IDX_W +: IDX_W]       <= lat_idx[b];
                  resp_data_valid[b]                     <= 1'b1;
                  done[b]                                <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gelato_register_bank_arbiter.sv
// Directed bench for gelato_register_bank_arbiter: hand-computed expectations
// checked with immediate assertions at each step.
module tb_gelato_register_bank_arbiter;

   logic        clk;
   logic        rst_n;
   logic        rdy;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_entry_valid;
   logic [7:0]  req_collector_num;
   logic [59:0] req_reg_num;
   logic [11:0] req_reg_valid;
   logic        resp_valid;
   logic        resp_ready;
   logic [3:0]  resp_data_valid;
   logic [7:0]  resp_collector_index;
   logic [7:0]  resp_reg_index;
   logic [127:0] resp_data;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;

   int total = 0;
   int bad   = 0;
   int lat;

   gelato_register_bank_arbiter #(
      .COLLECTOR_SIZE(4), .BANK_NUM(4), .REG_AW(5), .DATA_WIDTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_entry_valid(req_entry_valid), .req_collector_num(req_collector_num),
      .req_reg_num(req_reg_num), .req_reg_valid(req_reg_valid),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data_valid(resp_data_valid), .resp_collector_index(resp_collector_index),
      .resp_reg_index(resp_reg_index), .resp_data(resp_data),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_req();
      req_entry_valid   = '0;
      req_collector_num = '0;
      req_reg_num       = '0;
      req_reg_valid     = '0;
   endtask

   task automatic set_op(input int e, input int o, input logic [4:0] addr);
      req_entry_valid[e]            = 1'b1;
      req_reg_num[(e*3+o)*5 +: 5]   = addr;
      req_reg_valid[e*3+o]          = 1'b1;
   endtask

   task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
      wb_valid = 1'b1;
      wb_reg   = addr;
      wb_data  = data;
      tick();
      wb_valid = 1'b0;
   endtask

   // Accept the request, then count cycles until resp_valid (bounded).
   task automatic do_req(output int cycles);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      cycles = 0;
      while (!resp_valid && cycles < 20) begin
         tick();
         cycles++;
      end
   endtask

   task automatic accept_beat();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
      wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
      clear_req();
      tick(); tick();
      rst_n = 1'b1;
      tick();

      check("reset_req_ready", 64'(req_ready), 64'd1);
      check("reset_resp_valid", 64'(resp_valid), 64'd0);
      check("reset_data_valid", 64'(resp_data_valid), 64'h0);
      check("reset_resp_data_lo", resp_data[63:0], 64'h0);
      check("reset_tags", 64'({resp_collector_index, resp_reg_index}), 64'h0);

      // Basic two-bank read
      write_reg(5'd5, 32'hA5);
      write_reg(5'd6, 32'hB6);
      clear_req();
      set_op(0, 0, 5'd5);
      set_op(0, 1, 5'd6);
      req_collector_num[1:0] = 2'd2;
      do_req(lat);
      check("basic_latency", 64'(lat), 64'd2);
      check("basic_data_valid", 64'(resp_data_valid), 64'b0110);
      check("basic_b1_data", 64'(resp_data[63:32]), 64'hA5);
      check("basic_b2_data", 64'(resp_data[95:64]), 64'hB6);
      check("basic_b1_idx", 64'(resp_reg_index[3:2]), 64'd1);
      check("basic_b2_idx", 64'(resp_reg_index[5:4]), 64'd2);
      check("basic_tags", 64'({resp_collector_index[5:4], resp_collector_index[3:2]}), 64'b1010);
      check("basic_req_ready_busy", 64'(req_ready), 64'd0);
      accept_beat();
      check("basic_after_accept_valid", 64'(resp_valid), 64'd0);
      check("basic_after_accept_ready", 64'(req_ready), 64'd1);

      // Two operands in bank 0: scan order picks entry0 first
      write_reg(5'd4, 32'h44);
      write_reg(5'd8, 32'h88);
      clear_req();
      set_op(0, 0, 5'd4);
      set_op(1, 1, 5'd8);
      req_collector_num = 8'b0000_1101;
      do_req(lat);
      check("conf1_data_valid", 64'(resp_data_valid), 64'b0001);
      check("conf1_b0_data", 64'(resp_data[31:0]), 64'h44);
      check("conf1_b0_idx", 64'(resp_reg_index[1:0]), 64'd1);
      check("conf1_b0_tag", 64'(resp_collector_index[1:0]), 64'd1);
      accept_beat();
      req_entry_valid[0] = 1'b0;
      do_req(lat);
      check("conf2_data_valid", 64'(resp_data_valid), 64'b0001);
      check("conf2_b0_data", 64'(resp_data[31:0]), 64'h88);
      check("conf2_b0_idx", 64'(resp_reg_index[1:0]), 64'd2);
      check("conf2_b0_tag", 64'(resp_collector_index[1:0]), 64'd3);
      accept_beat();

      // Writeback hits the bank being read: one extra cycle, new value returned
      clear_req();
      set_op(0, 0, 5'd4);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h77;
      tick();
      wb_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("wbconf_latency", 64'(lat), 64'd3);
      check("wbconf_data_valid", 64'(resp_data_valid), 64'b0001);
      check("wbconf_b0_data", 64'(resp_data[31:0]), 64'h77);
      accept_beat();

      // Backpressure with a competing request and a write to the served register
      write_reg(5'd9, 32'h99);
      clear_req();
      set_op(2, 2, 5'd9);
      req_collector_num[5:4] = 2'd1;
      do_req(lat);
      clear_req();
      set_op(0, 0, 5'd5);
      req_valid = 1'b1;
      wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h1234;
      for (int i = 0; i < 5; i++) begin
         tick();
         wb_valid = 1'b0;
         check("bp_resp_valid", 64'(resp_valid), 64'd1);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_b1_fields", 64'({resp_data_valid, resp_collector_index[3:2],
                                    resp_reg_index[3:2], resp_data[63:32]}),
               64'({4'b0010, 2'd1, 2'd3, 32'h99}));
      end
      rdy = 1'b0;
      resp_ready = 1'b1;
      tick();
      check("rdy_low_holds_resp", 64'(resp_valid), 64'd1);
      rdy = 1'b1;
      tick();
      req_valid = 1'b0;
      resp_ready = 1'b0;
      check("bp_accepted_valid", 64'(resp_valid), 64'd0);
      check("bp_accepted_ready", 64'(req_ready), 64'd1);
      tick(); tick();
      check("bp_stays_idle", 64'(req_ready), 64'd1);

      // Empty request still produces a beat
      clear_req();
      req_entry_valid = 4'b1111;
      do_req(lat);
      check("empty_resp_valid", 64'(resp_valid), 64'd1);
      check("empty_data_valid", 64'(resp_data_valid), 64'b0000);
      accept_beat();
      check("empty_back_idle", 64'(req_ready), 64'd1);

      // Async reset during READ
      clear_req();
      set_op(0, 0, 5'd5);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("rst_in_read_busy", 64'(req_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_async_req_ready", 64'(req_ready), 64'd1);
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("rst_no_beat", 64'(resp_valid), 64'd0);
      do_req(lat);
      check("rst_read_latency", 64'(lat), 64'd2);
      check("rst_read_data_valid", 64'(resp_data_valid), 64'b0010);
      check("rst_read_zero", 64'(resp_data[63:32]), 64'h0);
      accept_beat();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
